// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one memory bus between fetch (ireq/iresp) and data (dreq/dresp) ports, downstream creq/cresp
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  input  logic [2:0]  ireq_size,
  output logic        iresp_data_ok,
  output logic [63:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        creq_valid,
  output logic [63:0] creq_addr,
  output logic [2:0]  creq_size,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_data,
  input  logic        cresp_data_ok,
  input  logic [63:0] cresp_data
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic owner, last_grant, abandoned, gnt_d, owner_valid, ok;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
  always_comb begin
    gnt_d = dreq_valid && (!ireq_valid || !last_grant);
    owner_valid = owner ? dreq_valid : ireq_valid;
    state_nxt = state == IDLE ? ((ireq_valid || dreq_valid) ? BUSY : IDLE)
                              : (cresp_data_ok ? IDLE : BUSY);
  end
  always_comb begin
    creq_valid = state == BUSY;
    ok = state == BUSY && cresp_data_ok && !abandoned && owner_valid;
    iresp_data_ok = ok && !owner;
    dresp_data_ok = ok && owner;
    iresp_data = cresp_data;
    dresp_data = cresp_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= 1'b0;
      last_grant <= 1'b0;
      abandoned <= 1'b0;
      creq_addr <= '0;
      creq_size <= '0;
      creq_strobe <= '0;
      creq_data <= '0;
    end else if (state == IDLE) begin
      if (ireq_valid || dreq_valid) begin
        owner <= gnt_d;
        abandoned <= 1'b0;
        creq_addr <= gnt_d ? dreq_addr : ireq_addr;
        creq_size <= gnt_d ? dreq_size : ireq_size;
        creq_strobe <= gnt_d ? dreq_strobe : '0;
        creq_data <= gnt_d ? dreq_data : '0;
      end
    end else begin
      if (!owner_valid) abandoned <= 1'b1;
      if (cresp_data_ok) last_grant <= owner;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  logic        clk = 1'b0, reset;
  logic        ireq_valid, dreq_valid, cresp_data_ok;
  logic [63:0] ireq_addr, dreq_addr, dreq_data, cresp_data;
  logic [2:0]  ireq_size, dreq_size;
  logic [7:0]  dreq_strobe;
  logic        iresp_data_ok, dresp_data_ok, creq_valid;
  logic [63:0] iresp_data, dresp_data, creq_addr, creq_data;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  int total = 0, bad = 0;
  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_size(ireq_size),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_addr(creq_addr), .creq_size(creq_size),
    .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_data_ok(cresp_data_ok), .cresp_data(cresp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    ireq_valid = 1'b0; ireq_addr = '0; ireq_size = '0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    cresp_data_ok = 1'b0; cresp_data = '0;
    tick; tick;
    #1;
    chk("rst_creq_valid", {63'd0, creq_valid}, 64'd0);
    chk("rst_creq_addr", creq_addr, 64'd0);
    chk("rst_creq_size", {61'd0, creq_size}, 64'd0);
    chk("rst_creq_strobe", {56'd0, creq_strobe}, 64'd0);
    chk("rst_creq_data", creq_data, 64'd0);
    chk("rst_iok", {63'd0, iresp_data_ok}, 64'd0);
    chk("rst_dok", {63'd0, dresp_data_ok}, 64'd0);
    reset = 1'b0;
    // single data read, downstream answers 3 cycles after creq_valid rises
    tick;
    dreq_valid = 1'b1; dreq_addr = 64'h8000_1000; dreq_size = 3'd3; dreq_strobe = 8'h00;
    #1 chk("rd_idle_valid", {63'd0, creq_valid}, 64'd0);
    tick;
    chk("rd_creq_valid", {63'd0, creq_valid}, 64'd1);
    chk("rd_creq_addr", creq_addr, 64'h8000_1000);
    chk("rd_creq_size", {61'd0, creq_size}, 64'd3);
    chk("rd_busy_dok", {63'd0, dresp_data_ok}, 64'd0);
    tick; tick; tick;
    cresp_data_ok = 1'b1; cresp_data = 64'h1122_3344_5566_7788;
    #1;
    chk("rd_dok", {63'd0, dresp_data_ok}, 64'd1);
    chk("rd_ddata", dresp_data, 64'h1122_3344_5566_7788);
    chk("rd_iok", {63'd0, iresp_data_ok}, 64'd0);
    tick;
    cresp_data_ok = 1'b0; dreq_valid = 1'b0;
    #1;
    chk("rd_after_valid", {63'd0, creq_valid}, 64'd0);
    chk("rd_after_dok", {63'd0, dresp_data_ok}, 64'd0);
    // tie round-robin from reset, data is a write, fetch must drive zero strobe/data
    reset = 1'b1;
    ireq_valid = 1'b1; ireq_addr = 64'h1000; ireq_size = 3'd2;
    dreq_valid = 1'b1; dreq_addr = 64'h100; dreq_strobe = 8'h0F; dreq_data = 64'hDEAD_BEEF;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("rr%0d_valid", k), {63'd0, creq_valid}, 64'd1);
      chk($sformatf("rr%0d_addr", k), creq_addr, k % 2 == 0 ? 64'h100 : 64'h1000);
      chk($sformatf("rr%0d_strobe", k), {56'd0, creq_strobe}, k % 2 == 0 ? 64'h0F : 64'h0);
      chk($sformatf("rr%0d_data", k), creq_data, k % 2 == 0 ? 64'hDEAD_BEEF : 64'h0);
      tick;
      chk($sformatf("rr%0d_strobe_hold", k), {56'd0, creq_strobe}, k % 2 == 0 ? 64'h0F : 64'h0);
      cresp_data_ok = 1'b1; cresp_data = 64'hA0 + 64'(k);
      #1;
      chk($sformatf("rr%0d_dok", k), {63'd0, dresp_data_ok}, k % 2 == 0 ? 64'd1 : 64'd0);
      chk($sformatf("rr%0d_iok", k), {63'd0, iresp_data_ok}, k % 2 == 0 ? 64'd0 : 64'd1);
      tick;
      cresp_data_ok = 1'b0;
      #1 chk($sformatf("rr%0d_gap", k), {63'd0, creq_valid}, 64'd0);
    end
    ireq_valid = 1'b0; dreq_valid = 1'b0;
    tick;
    // idle response is ignored
    cresp_data_ok = 1'b1;
    #1;
    chk("idle_iok", {63'd0, iresp_data_ok}, 64'd0);
    chk("idle_dok", {63'd0, dresp_data_ok}, 64'd0);
    tick;
    cresp_data_ok = 1'b0;
    // abandon: fetch drops valid for a cycle and returns with a new address
    ireq_valid = 1'b1; ireq_addr = 64'h1000;
    tick;
    chk("ab_valid", {63'd0, creq_valid}, 64'd1);
    chk("ab_addr1", creq_addr, 64'h1000);
    chk("ab_strobe", {56'd0, creq_strobe}, 64'd0);
    ireq_valid = 1'b0;
    tick;
    ireq_valid = 1'b1; ireq_addr = 64'h2000;
    tick;
    chk("ab_addr_hold", creq_addr, 64'h1000);
    cresp_data_ok = 1'b1; cresp_data = 64'h5555;
    #1 chk("ab_first_iok", {63'd0, iresp_data_ok}, 64'd0);
    tick;
    cresp_data_ok = 1'b0;
    #1 chk("ab_gap", {63'd0, creq_valid}, 64'd0);
    tick;
    chk("ab_addr2", creq_addr, 64'h2000);
    cresp_data_ok = 1'b1; cresp_data = 64'h6666;
    #1;
    chk("ab_second_iok", {63'd0, iresp_data_ok}, 64'd1);
    chk("ab_second_idata", iresp_data, 64'h6666);
    tick;
    cresp_data_ok = 1'b0; ireq_valid = 1'b0;
    // stable request: address change during BUSY is not seen downstream
    dreq_valid = 1'b1; dreq_addr = 64'h100; dreq_strobe = 8'h00;
    tick;
    chk("st_addr0", creq_addr, 64'h100);
    dreq_addr = 64'h200; dreq_strobe = 8'hFF;
    tick;
    chk("st_addr1", creq_addr, 64'h100);
    chk("st_strobe1", {56'd0, creq_strobe}, 64'd0);
    cresp_data_ok = 1'b1; cresp_data = 64'h7777;
    #1;
    chk("st_addr2", creq_addr, 64'h100);
    chk("st_dok", {63'd0, dresp_data_ok}, 64'd1);
    tick;
    cresp_data_ok = 1'b0; dreq_valid = 1'b0;
    // reset mid-BUSY; last grant was data, reset must restore data priority on ties
    ireq_valid = 1'b1; ireq_addr = 64'h3000;
    tick;
    chk("rb_busy", {63'd0, creq_valid}, 64'd1);
    dreq_valid = 1'b1; dreq_addr = 64'h4000;
    reset = 1'b1;
    tick;
    chk("rb_valid", {63'd0, creq_valid}, 64'd0);
    chk("rb_addr", creq_addr, 64'd0);
    cresp_data_ok = 1'b1;
    #1;
    chk("rb_iok", {63'd0, iresp_data_ok}, 64'd0);
    chk("rb_dok", {63'd0, dresp_data_ok}, 64'd0);
    reset = 1'b0; cresp_data_ok = 1'b0;
    tick;
    chk("rb_grant_valid", {63'd0, creq_valid}, 64'd1);
    chk("rb_grant_addr", creq_addr, 64'h4000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
